// File: rtl/object_spawner_if.sv
// Launch-parameter bundle between the object spawner and the motion stage.
// The spawner is the master: it drives the parameters and takes en/obj_done.
interface object_spawner_if;
    logic        en;
    logic        obj_done;
    logic [9:0]  initposx;
    logic [8:0]  initposy;
    logic [31:0] Tx;
    logic [31:0] Ty;
    logic        dx;
    logic        dy;
    logic        spawn;
    logic        active;

    modport master (
        input  en, obj_done,
        output initposx, initposy, Tx, Ty, dx, dy, spawn, active
    );

    modport slave (
        output en, obj_done,
        input  initposx, initposy, Tx, Ty, dx, dy, spawn, active
    );
endinterface

// File: rtl/object_spawner.sv
// Picks pseudo-random launch parameters for one object and re-arms once the
// motion stage reports it finished.
//
// state | meaning
// IDLE  | launching disabled, waiting for en
// COUNT | gap timer running down to zero
// DRAW  | random word captured, parameters loaded at exit
// ISSUE | spawn pulse, new parameters valid
// HOLD  | object in flight, waiting for obj_done
module object_spawner #(
    parameter int unsigned SCREEN_W  = 640,
    parameter int unsigned X_MIN     = 64,
    parameter int unsigned X_SPAN    = 512,
    parameter int unsigned LAUNCH_Y  = 470,
    parameter int unsigned TX_BASE   = 200000,
    parameter int unsigned TY_BASE   = 100000,
    parameter int unsigned T_SHIFT   = 10,
    parameter int unsigned SPAWN_GAP = 50000000,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst,
    object_spawner_if.master sp
);
    localparam int unsigned GAP  = (SPAWN_GAP == 0) ? 1 : SPAWN_GAP;
    localparam logic [15:0] SEED = (LFSR_SEED == 16'h0) ? 16'hACE1 : LFSR_SEED;
    localparam logic [31:0] CNT_RELOAD = 32'(GAP - 1);

    typedef enum logic [2:0] {IDLE, COUNT, DRAW, ISSUE, HOLD} state_t;

    state_t      state, state_nxt;
    logic [31:0] cnt, cnt_nxt;
    logic [15:0] lfsr, lfsr_nxt;
    logic        load;
    logic [9:0]  x_new;
    logic [31:0] tx_new, ty_new;

    // Galois form of x^16+x^14+x^13+x^11+1, shifting right
    always_comb begin
        lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Parameters come straight from the DRAW-cycle LFSR word so they are
    // already valid in the cycle spawn is high.
    always_comb begin
        x_new  = 10'(18'(X_MIN) + ((18'(lfsr[7:0]) * 18'(X_SPAN)) >> 8));
        tx_new = 32'(TX_BASE) + (32'(lfsr[13:8]) << T_SHIFT);
        ty_new = 32'(TY_BASE) + (32'(lfsr[15:14]) << T_SHIFT);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        if (!sp.en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = COUNT;
                    cnt_nxt   = CNT_RELOAD;
                end
                COUNT: begin
                    if (cnt == 32'd0) state_nxt = DRAW;
                    else              cnt_nxt   = cnt - 32'd1;
                end
                DRAW: begin
                    state_nxt = ISSUE;
                    load      = 1'b1;
                end
                ISSUE: state_nxt = HOLD;
                HOLD: begin
                    if (sp.obj_done) begin
                        state_nxt = COUNT;
                        cnt_nxt   = CNT_RELOAD;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= 32'd0;
            lfsr        <= SEED;
            sp.initposx <= 10'(SCREEN_W / 2);
            sp.initposy <= 9'(LAUNCH_Y);
            sp.Tx       <= 32'(TX_BASE);
            sp.Ty       <= 32'(TY_BASE);
            sp.dx       <= 1'b0;
            sp.dy       <= 1'b0;
            sp.spawn    <= 1'b0;
            sp.active   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            lfsr      <= lfsr_nxt;
            sp.spawn  <= (state_nxt == ISSUE);
            sp.active <= (state_nxt == ISSUE) || (state_nxt == HOLD);
            if (load) begin
                sp.initposx <= x_new;
                sp.initposy <= 9'(LAUNCH_Y);
                sp.Tx       <= tx_new;
                sp.Ty       <= ty_new;
                sp.dx       <= (x_new < 10'(SCREEN_W / 2));
                sp.dy       <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_object_spawner.sv
// Directed bench for object_spawner: one instance with a 4-cycle gap, one with
// gap 0 (treated as 1) for the long launch run.
module tb_object_spawner;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    object_spawner_if ifa ();
    object_spawner_if ifb ();

    object_spawner #(.SPAWN_GAP(4)) u_dut_a (.clk(clk), .rst(rst), .sp(ifa));
    object_spawner #(.SPAWN_GAP(0)) u_dut_b (.clk(clk), .rst(rst), .sp(ifb));

    // reference LFSR; m_prev is the word the DUT held one cycle earlier (DRAW)
    logic [15:0] m_lfsr, m_prev;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        logic [15:0] r;
        r = v >> 1;
        if (v[0]) r = r ^ 16'hB400;
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_lfsr <= 16'hACE1;
            m_prev <= 16'hACE1;
        end else begin
            m_prev <= m_lfsr;
            m_lfsr <= lfsr_step(m_lfsr);
        end
    end

    // {x, y, Tx, Ty, dx} expected from a random word
    function automatic logic [83:0] exp_params(input logic [15:0] r);
        logic [9:0] x;
        x = 10'd64 + {1'b0, r[7:0], 1'b0};
        return {x, 9'd470, 32'd200000 + {r[13:8], 10'b0},
                32'd100000 + {r[15:14], 10'b0}, (x < 10'd320)};
    endfunction

    localparam logic [86:0] RESET_VEC = {10'd320, 9'd470, 32'd200000, 32'd100000, 4'b0000};

    logic [86:0] got, expv, saved;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.en = 1'b0; ifa.obj_done = 1'b0;
        ifb.en = 1'b0; ifb.obj_done = 1'b0;
        step();
        step();
        rst = 1'b0;
        got = {ifa.initposx, ifa.initposy, ifa.Tx, ifa.Ty, ifa.dx, ifa.dy, ifa.spawn, ifa.active};
        tests++;
        if (got !== RESET_VEC) begin
            fails++; $display("FAIL reset_a got %h exp %h", got, RESET_VEC);
        end
        got = {ifb.initposx, ifb.initposy, ifb.Tx, ifb.Ty, ifb.dx, ifb.dy, ifb.spawn, ifb.active};
        tests++;
        if (got !== RESET_VEC) begin
            fails++; $display("FAIL reset_b got %h exp %h", got, RESET_VEC);
        end
    endtask

    task automatic test_first_spawn();
        ifa.en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            tests++;
            if (ifa.spawn !== (k == 6)) begin
                fails++; $display("FAIL first_latency k=%0d spawn got %b exp %b", k, ifa.spawn, k == 6);
            end
        end
        got  = {ifa.initposx, ifa.initposy, ifa.Tx, ifa.Ty, ifa.dx, ifa.dy, ifa.spawn, ifa.active};
        expv = {exp_params(m_prev), 1'b0, 1'b1, 1'b1};
        tests++;
        if (got !== expv) begin
            fails++; $display("FAIL first_params got %h exp %h", got, expv);
        end
        // no re-launch without obj_done, everything bit-stable
        expv = {expv[86:2], 1'b0, 1'b1};
        for (int k = 0; k < 20; k++) begin
            step();
            got = {ifa.initposx, ifa.initposy, ifa.Tx, ifa.Ty, ifa.dx, ifa.dy, ifa.spawn, ifa.active};
            tests++;
            if (got !== expv) begin
                fails++; $display("FAIL hold_stable k=%0d got %h exp %h", k, got, expv);
            end
        end
    endtask

    task automatic test_obj_done();
        ifa.obj_done = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) ifa.obj_done = 1'b0;
            tests++;
            if (ifa.spawn !== (k == 6)) begin
                fails++; $display("FAIL rearm_latency k=%0d spawn got %b exp %b", k, ifa.spawn, k == 6);
            end
        end
        got  = {ifa.initposx, ifa.initposy, ifa.Tx, ifa.Ty, ifa.dx, ifa.dy, ifa.spawn, ifa.active};
        expv = {exp_params(m_prev), 1'b0, 1'b1, 1'b1};
        tests++;
        if (got !== expv) begin
            fails++; $display("FAIL rearm_params got %h exp %h", got, expv);
        end
        tests++;
        if (ifa.initposx < 10'd64 || ifa.initposx > 10'd575) begin
            fails++; $display("FAIL rearm_x_range got %0d exp 64..575", ifa.initposx);
        end
        tests++;
        if (ifa.dx !== (ifa.initposx < 10'd320)) begin
            fails++; $display("FAIL rearm_dx got %b exp %b", ifa.dx, ifa.initposx < 10'd320);
        end
        tests++;
        if (((ifa.Tx - 32'd200000) % 32'd1024) != 0 || (ifa.Tx - 32'd200000) > 32'd64512
            || ifa.Tx < 32'd200000) begin
            fails++; $display("FAIL rearm_tx_range got %0d exp 200000+k*1024 k<=63", ifa.Tx);
        end
    endtask

    task automatic test_en_drop();
        saved = {ifa.initposx, ifa.initposy, ifa.Tx, ifa.Ty, ifa.dx, ifa.dy, 2'b00};
        ifa.en = 1'b0;
        step();
        got = {ifa.initposx, ifa.initposy, ifa.Tx, ifa.Ty, ifa.dx, ifa.dy, ifa.spawn, ifa.active};
        tests++;
        if (got !== saved) begin
            fails++; $display("FAIL en_off_hold got %h exp %h", got, saved);
        end
        ifa.en = 1'b1;
        step();
        step();
        ifa.en = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            got = {ifa.initposx, ifa.initposy, ifa.Tx, ifa.Ty, ifa.dx, ifa.dy, ifa.spawn, ifa.active};
            tests++;
            if (got !== saved) begin
                fails++; $display("FAIL count_abort k=%0d got %h exp %h", k, got, saved);
            end
        end
        ifa.en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            tests++;
            if (ifa.spawn !== (k == 6)) begin
                fails++; $display("FAIL restart_latency k=%0d spawn got %b exp %b", k, ifa.spawn, k == 6);
            end
        end
        got  = {ifa.initposx, ifa.initposy, ifa.Tx, ifa.Ty, ifa.dx, ifa.dy, ifa.spawn, ifa.active};
        expv = {exp_params(m_prev), 1'b0, 1'b1, 1'b1};
        tests++;
        if (got !== expv) begin
            fails++; $display("FAIL restart_params got %h exp %h", got, expv);
        end
    endtask

    task automatic test_rst_hold();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        got = {ifa.initposx, ifa.initposy, ifa.Tx, ifa.Ty, ifa.dx, ifa.dy, ifa.spawn, ifa.active};
        tests++;
        if (got !== RESET_VEC) begin
            fails++; $display("FAIL rst_in_hold got %h exp %h", got, RESET_VEC);
        end
        // obj_done high through IDLE/COUNT/DRAW must not disturb the gap
        ifa.obj_done = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step();
            tests++;
            if (ifa.spawn !== (k == 6)) begin
                fails++; $display("FAIL done_ignored k=%0d spawn got %b exp %b", k, ifa.spawn, k == 6);
            end
            if (k == 6) ifa.obj_done = 1'b0;
        end
        got  = {ifa.initposx, ifa.initposy, ifa.Tx, ifa.Ty, ifa.dx, ifa.dy, ifa.spawn, ifa.active};
        expv = {exp_params(m_prev), 1'b0, 1'b1, 1'b1};
        tests++;
        if (got !== expv) begin
            fails++; $display("FAIL post_rst_params got %h exp %h", got, expv);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            tests++;
            if ({ifa.spawn, ifa.active} !== 2'b01) begin
                fails++; $display("FAIL post_rst_hold k=%0d spawn/active got %b%b exp 01", k, ifa.spawn, ifa.active);
            end
        end
    endtask

    task automatic test_many_launches();
        logic [83:0] prev_p, cur_p;
        bit saw_dx0, saw_dx1, found;
        int waited, exp_wait;
        saw_dx0 = 0; saw_dx1 = 0;
        prev_p  = '0;
        ifb.en  = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            found = 0; waited = 0;
            while (!found && waited < 10) begin
                step();
                waited++;
                if (ifb.spawn === 1'b1) found = 1;
            end
            exp_wait = (n == 0) ? 3 : 2;
            tests++;
            if (!found || waited != exp_wait) begin
                fails++; $display("FAIL gap1_latency n=%0d got %0d cycles exp %0d", n, waited, exp_wait);
                break;
            end
            cur_p = {ifb.initposx, ifb.initposy, ifb.Tx, ifb.Ty, ifb.dx};
            tests++;
            if (cur_p !== exp_params(m_prev)) begin
                fails++; $display("FAIL gap1_params n=%0d got %h exp %h", n, cur_p, exp_params(m_prev));
            end
            tests++;
            if (ifb.initposx < 10'd64 || ifb.initposx > 10'd575) begin
                fails++; $display("FAIL gap1_x_range n=%0d got %0d exp 64..575", n, ifb.initposx);
            end
            tests++;
            if (cur_p === prev_p) begin
                fails++; $display("FAIL gap1_repeat n=%0d got %h exp different from %h", n, cur_p, prev_p);
            end
            if (ifb.dx) saw_dx1 = 1; else saw_dx0 = 1;
            prev_p = cur_p;
            step();
            ifb.obj_done = 1'b1;
            step();
            ifb.obj_done = 1'b0;
        end
        tests++;
        if (!(saw_dx0 && saw_dx1)) begin
            fails++; $display("FAIL gap1_dx_both got dx0=%0d dx1=%0d exp 1 1", saw_dx0, saw_dx1);
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_obj_done();
        test_en_drop();
        test_rst_hold();
        test_many_launches();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
